// File: rtl/cdb_slot_scheduler_if.sv
// rtl/cdb_slot_scheduler_if.sv - issue request/grant and CDB ownership signals
interface cdb_slot_scheduler_if #(
  parameter int NUM_CH  = 4,
  parameter int CH_ID_W = 2
);
  logic [NUM_CH-1:0]  req_i;
  logic [NUM_CH-1:0]  grant_o;
  logic               cdb_valid_o;
  logic [CH_ID_W-1:0] cdb_ch_o;

  modport master (output req_i, input grant_o, cdb_valid_o, cdb_ch_o);
  modport slave  (input req_i, output grant_o, cdb_valid_o, cdb_ch_o);
endinterface

// File: rtl/cdb_slot_scheduler.sv
// rtl/cdb_slot_scheduler.sv - CDB write-slot scheduler with rotating same-slot priority
// Optional per-channel stall counters are built when CDB_PERF_CNT_EN is defined.
module cdb_slot_scheduler #(
  parameter int                  NUM_CH  = 4,
  parameter int                  CH_ID_W = 2,
  parameter int                  MAX_LAT = 8,
  parameter logic [4*NUM_CH-1:0] CH_LAT  = {4'd7, 4'd4, 4'd1, 4'd1}
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   flush,
  cdb_slot_scheduler_if.slave    bus,
  output logic [16*NUM_CH-1:0]   stall_cnt_o
);
  localparam int IDX_W = $clog2(MAX_LAT);

  typedef struct packed {
    logic               valid;
    logic [CH_ID_W-1:0] ch;
  } slot_t;

  // Entry MAX_LAT-1 is never written, so it always reads as a free slot.
  slot_t              slot_q [MAX_LAT];
  slot_t              slot_d [MAX_LAT];
  logic [CH_ID_W-1:0] rr_q, rr_d;
  logic [NUM_CH-1:0]  elig, gnt;
  int                 lat [NUM_CH];
  logic               l1_v;
  logic [CH_ID_W-1:0] l1_ch;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) lat[c] = int'(CH_LAT[c*4 +: 4]);
  end

  always_comb begin
    logic shared, won, contend;
    int   win, dc, dof;
    shared  = 1'b0;
    won     = 1'b0;
    contend = 1'b0;
    win     = NUM_CH;
    dc      = 0;
    dof     = 0;
    elig    = '0;
    gnt     = '0;
    for (int c = 0; c < NUM_CH; c++)
      elig[c] = bus.req_i[c] & ~slot_q[IDX_W'(lat[c] - 1)].valid;
    // Channels with equal latency target the same CDB cycle; nearest to rr wins.
    for (int c = 0; c < NUM_CH; c++) begin
      if (elig[c]) begin
        won    = 1'b1;
        shared = 1'b0;
        dc     = (c - int'(rr_q) + NUM_CH) % NUM_CH;
        for (int o = 0; o < NUM_CH; o++) begin
          if (o != c && elig[o] && lat[o] == lat[c]) begin
            shared = 1'b1;
            dof    = (o - int'(rr_q) + NUM_CH) % NUM_CH;
            if (dof < dc) won = 1'b0;
          end
        end
        if (won) begin
          gnt[c] = 1'b1;
          if (shared) begin
            contend = 1'b1;
            if (c < win) win = c;
          end
        end
      end
    end
    if (flush) gnt = '0;
    rr_d = contend ? CH_ID_W'((win + 1) % NUM_CH) : rr_q;
  end

  always_comb begin
    for (int i = 0; i < MAX_LAT - 1; i++) slot_d[i] = slot_q[i+1];
    slot_d[MAX_LAT-1] = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (gnt[c] && lat[c] >= 2) slot_d[IDX_W'(lat[c] - 2)] = {1'b1, CH_ID_W'(c)};
  end

  // Latency-1 grants drive the CDB directly; they can only win when slot 0 is free.
  always_comb begin
    l1_v  = 1'b0;
    l1_ch = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt[c] && lat[c] == 1) begin
        l1_v  = 1'b1;
        l1_ch = CH_ID_W'(c);
      end
    end
    bus.grant_o     = gnt;
    bus.cdb_valid_o = ~flush & (slot_q[0].valid | l1_v);
    bus.cdb_ch_o    = '0;
    if (!flush) begin
      if (slot_q[0].valid) bus.cdb_ch_o = slot_q[0].ch;
      else if (l1_v)       bus.cdb_ch_o = l1_ch;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || flush) begin
      for (int i = 0; i < MAX_LAT; i++) slot_q[i] <= '0;
      rr_q <= '0;
    end else begin
      for (int i = 0; i < MAX_LAT; i++) slot_q[i] <= slot_d[i];
      rr_q <= rr_d;
    end
  end

`ifdef CDB_PERF_CNT_EN
  logic [15:0] cnt_q [NUM_CH];

  // Counters survive flush so stall history spans pipeline recoveries.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        if (bus.req_i[c] && !gnt[c] && !flush && cnt_q[c] != 16'hFFFF)
          cnt_q[c] <= cnt_q[c] + 16'd1;
    end
  end

  always_comb begin
    stall_cnt_o = '0;
    for (int c = 0; c < NUM_CH; c++) stall_cnt_o[16*c +: 16] = cnt_q[c];
  end
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cdb_slot_scheduler.sv
// tb/tb_cdb_slot_scheduler.sv - scoreboard bench for cdb_slot_scheduler
module tb_cdb_slot_scheduler;
  localparam int NUM_CH  = 4;
  localparam int CH_ID_W = 2;
`ifdef CDB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] stall;

  cdb_slot_scheduler_if #(.NUM_CH(NUM_CH), .CH_ID_W(CH_ID_W)) bus ();

  cdb_slot_scheduler #(
    .NUM_CH (NUM_CH),
    .CH_ID_W(CH_ID_W),
    .MAX_LAT(8),
    .CH_LAT (16'h7411)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .flush      (flush),
    .bus        (bus.slave),
    .stall_cnt_o(stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        chk_out;
    logic [3:0]  g;
    logic        v;
    logic [1:0]  ch;
    logic        chk_st;
    logic [63:0] st;
    logic [15:0] id;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [15:0] tag    = '0;

  task automatic cmp(input string name, input logic [15:0] id, input logic [63:0] act,
                     input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s vec%0d: got %0h want %0h", name, id, act, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk_out) begin
          cmp("grant", e.id, {60'd0, bus.grant_o}, {60'd0, e.g});
          cmp("cdb_valid", e.id, {63'd0, bus.cdb_valid_o}, {63'd0, e.v});
          cmp("cdb_ch", e.id, {62'd0, bus.cdb_ch_o}, {62'd0, e.ch});
        end
        if (e.chk_st) cmp("stall_cnt", e.id, stall, e.st);
      end
    end
  end

  task automatic drive(input logic r, input logic f, input logic [3:0] q);
    @(posedge clk);
    #1;
    rst_n       = r;
    flush       = f;
    bus.req_i   = q;
    tag         = tag + 16'd1;
  endtask

  task automatic cyc(input logic r, input logic f, input logic [3:0] q,
                     input logic [3:0] g, input logic v, input logic [1:0] ch);
    exp_t e;
    drive(r, f, q);
    e         = '0;
    e.chk_out = 1'b1;
    e.g       = g;
    e.v       = v;
    e.ch      = ch;
    e.id      = tag;
    exp_q.push_back(e);
  endtask

  task automatic stall_chk(input logic [63:0] st);
    exp_t e;
    e        = '0;
    e.chk_st = 1'b1;
    e.st     = PERF ? st : 64'd0;
    e.id     = tag;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0);
  endtask

  initial begin : stim
    bus.req_i = '0;
    drive(1'b0, 1'b0, 4'b0000);
    cyc(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0);
    stall_chk(64'd0);
    // latency-1 channel owns the CDB in its grant cycle
    cyc(1'b1, 1'b0, 4'b0001, 4'b0001, 1'b1, 2'd0);
    idle(1);
    // two latency-1 channels contend; priority rotates
    cyc(1'b1, 1'b0, 4'b0011, 4'b0001, 1'b1, 2'd0);
    cyc(1'b1, 1'b0, 4'b0011, 4'b0010, 1'b1, 2'd1);
    cyc(1'b1, 1'b0, 4'b0011, 4'b0001, 1'b1, 2'd0);
    idle(1);
    // ch2 (L=4) owns CDB three cycles later and blocks ch0
    cyc(1'b1, 1'b0, 4'b0100, 4'b0100, 1'b0, 2'd0);
    idle(2);
    cyc(1'b1, 1'b0, 4'b0001, 4'b0000, 1'b1, 2'd2);
    idle(1);
    // ch3 (L=7) reservation denies ch2 once, then ch2 lands right behind
    cyc(1'b1, 1'b0, 4'b1000, 4'b1000, 1'b0, 2'd0);
    idle(2);
    cyc(1'b1, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'd0);
    cyc(1'b1, 1'b0, 4'b0100, 4'b0100, 1'b0, 2'd0);
    idle(1);
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd3);
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd2);
    idle(1);
    // all request: one L1 winner plus independent ch2/ch3 grants
    cyc(1'b1, 1'b0, 4'b1111, 4'b1110, 1'b1, 2'd1);
    cyc(1'b1, 1'b0, 4'b0011, 4'b0001, 1'b1, 2'd0);
    idle(1);
    cyc(1'b1, 1'b0, 4'b0011, 4'b0000, 1'b1, 2'd2);
    idle(2);
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd3);
    idle(1);
    // flush drops ch3 reservation, blocks grants and resets rr to 0
    cyc(1'b1, 1'b0, 4'b1000, 4'b1000, 1'b0, 2'd0);
    idle(1);
    cyc(1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 2'd0);
    idle(8);
    cyc(1'b1, 1'b0, 4'b0011, 4'b0001, 1'b1, 2'd0);
    cyc(1'b1, 1'b0, 4'b0011, 4'b0010, 1'b1, 2'd1);
    // ch2 blocked three cycles by back-to-back ch3 reservations
    drive(1'b0, 1'b0, 4'b0000);
    cyc(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0);
    stall_chk(64'd0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 4'b1000, 4'b1000, 1'b0, 2'd0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'd0);
    cyc(1'b1, 1'b0, 4'b0100, 4'b0100, 1'b1, 2'd3);
    stall_chk(64'h0000_0003_0000_0000);
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd3);
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd3);
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd2);
    idle(1);
`ifdef CDB_PERF_CNT_EN
    drive(1'b0, 1'b0, 4'b0000);
    drive(1'b0, 1'b0, 4'b0000);
    repeat (70000) drive(1'b1, 1'b0, 4'b1100);
    stall_chk(64'h0000_FFFF_0000_0000);
`endif
    drive(1'b1, 1'b0, 4'b0000);
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d records left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
